// File: rtl/dma_fifo_sched.sv
// dma_fifo_sched: round-robin write arbiter and credit-based read scheduler
// in front of a shared DMA staging FIFO with an OUTPUT_DELAY read pipe.
// Read data is re-timed through a small skid queue onto a valid/ready stream.
module dma_fifo_sched #(
    parameter int NREQ         = 4,
    parameter int WIDTH        = 128,
    parameter int OUTPUT_DELAY = 1,
    parameter int SKID_DEPTH   = OUTPUT_DELAY + 2
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      clear_i,
    input  logic [NREQ-1:0]           req_valid_i,
    input  logic [NREQ*WIDTH-1:0]     req_data_i,
    output logic [NREQ-1:0]           req_ready_o,
    output logic                      fifo_write_o,
    output logic [WIDTH-1:0]          fifo_wdata_o,
    output logic                      fifo_read_o,
    output logic                      fifo_clear_o,
    input  logic [WIDTH-1:0]          fifo_rdata_i,
    input  logic                      fifo_full_i,
    input  logic                      fifo_empty_i,
    output logic                      out_valid_o,
    output logic [WIDTH-1:0]          out_data_o,
    input  logic                      out_ready_i,
    output logic [$clog2(NREQ)-1:0]   grant_id_o,
    output logic                      busy_o
);
    // state | meaning
    // RUN   | normal arbitration, reads and skid pushes
    // FLUSH | OUTPUT_DELAY cycles discarding the stale FIFO output pipe

    localparam int IDW = $clog2(NREQ);
    localparam int PW  = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
    localparam int CW  = $clog2(SKID_DEPTH + OUTPUT_DELAY + 1) + 1;
    localparam int FW  = $clog2(OUTPUT_DELAY + 1);

    typedef enum logic {RUN, FLUSH} state_t;

    state_t                  state, state_nxt;
    logic [FW-1:0]           flush_cnt, flush_cnt_nxt;
    logic [IDW-1:0]          rr_ptr, grant_idx, arb_cand;
    int                      arb_idx;
    logic                    grant_vld;
    logic                    run;
    logic [OUTPUT_DELAY-1:0] infl_pipe;
    logic [CW-1:0]           infl_cnt, skid_cnt, used;
    logic [WIDTH-1:0]        skid_mem [SKID_DEPTH];
    logic [PW-1:0]           head, tail;
    logic                    push, pop;

    assign run = (state == RUN);

    // Next state: clear always (re)enters FLUSH; FLUSH counts down to RUN
    always_comb begin
        state_nxt     = state;
        flush_cnt_nxt = flush_cnt;
        if (clear_i) begin
            state_nxt     = FLUSH;
            flush_cnt_nxt = FW'(OUTPUT_DELAY);
        end else if (state == FLUSH) begin
            if (flush_cnt == FW'(1)) begin
                state_nxt = RUN;
            end
            flush_cnt_nxt = flush_cnt - FW'(1);
        end
    end

    // Round-robin search starting just after the last granted requester
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        arb_idx   = 0;
        arb_cand  = '0;
        if (run && !clear_i && !fifo_full_i) begin
            for (int k = 1; k <= NREQ; k++) begin
                arb_idx  = (int'(rr_ptr) + k) % NREQ;
                arb_cand = IDW'(arb_idx);
                if (!grant_vld && req_valid_i[arb_cand]) begin
                    grant_vld = 1'b1;
                    grant_idx = arb_cand;
                end
            end
        end
    end

    // Write-port drive from the granted requester
    always_comb begin
        req_ready_o  = '0;
        fifo_wdata_o = '0;
        if (grant_vld) begin
            req_ready_o[grant_idx] = 1'b1;
            fifo_wdata_o           = req_data_i[int'(grant_idx)*WIDTH +: WIDTH];
        end
    end

    assign fifo_write_o = grant_vld;
    assign grant_id_o   = grant_idx;
    assign fifo_clear_o = clear_i;

    // Number of reads still travelling through the FIFO output pipe
    always_comb begin
        infl_cnt = '0;
        for (int i = 0; i < OUTPUT_DELAY; i++) begin
            infl_cnt = infl_cnt + CW'(infl_pipe[i]);
        end
    end

    // Credit counts the slot freed by a pop this cycle so the skid never overflows
    assign pop         = out_valid_o & out_ready_i;
    assign used        = skid_cnt + infl_cnt - CW'(pop);
    assign fifo_read_o = run & ~clear_i & ~fifo_empty_i & (used < CW'(SKID_DEPTH));
    assign push        = infl_pipe[OUTPUT_DELAY-1] & run & ~clear_i;

    assign out_valid_o = (skid_cnt != '0);
    assign out_data_o  = out_valid_o ? skid_mem[head] : '0;
    assign busy_o      = ~fifo_empty_i | (|infl_pipe) | out_valid_o | (state == FLUSH);

    // FSM state, flush timer and RR pointer (pointer survives clear)
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= RUN;
            flush_cnt <= '0;
            rr_ptr    <= IDW'(NREQ - 1);
        end else begin
            state     <= state_nxt;
            flush_cnt <= flush_cnt_nxt;
            if (grant_vld) begin
                rr_ptr <= grant_idx;
            end
        end
    end

    // In-flight tracker mirrors the FIFO read-to-data delay
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            infl_pipe <= '0;
        end else if (clear_i) begin
            infl_pipe <= '0;
        end else begin
            infl_pipe[0] <= fifo_read_o;
            for (int i = 1; i < OUTPUT_DELAY; i++) begin
                infl_pipe[i] <= infl_pipe[i-1];
            end
        end
    end

    // Skid queue pointers and occupancy
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            head     <= '0;
            tail     <= '0;
            skid_cnt <= '0;
        end else if (clear_i) begin
            head     <= '0;
            tail     <= '0;
            skid_cnt <= '0;
        end else begin
            if (push) begin
                tail <= (tail == PW'(SKID_DEPTH - 1)) ? '0 : tail + PW'(1);
            end
            if (pop) begin
                head <= (head == PW'(SKID_DEPTH - 1)) ? '0 : head + PW'(1);
            end
            skid_cnt <= skid_cnt + CW'(push) - CW'(pop);
        end
    end

    // Skid storage, datapath only
    always_ff @(posedge clk) begin
        if (push) begin
            skid_mem[tail] <= fifo_rdata_i;
        end
    end

    a_no_skid_overflow: assert property (@(posedge clk) disable iff (!rstn)
        !(push && skid_cnt == CW'(SKID_DEPTH)));

endmodule

// File: tb/tb_dma_fifo_sched.sv
// Bench for dma_fifo_sched: environment FIFO model plus a queue-based
// reference of arbitration, credit, in-flight delay and skid contents.
module tb_dma_fifo_sched;
    localparam int NREQ   = 4;
    localparam int WIDTH  = 128;
    localparam int OD     = 1;
    localparam int SKID   = OD + 2;
    localparam int IDW    = 2;
    localparam int FDEPTH = 16;

    logic                  clk = 1'b0;
    logic                  rstn = 1'b0;
    logic                  clear_i = 1'b0;
    logic [NREQ-1:0]       req_valid_i = '0;
    logic [NREQ*WIDTH-1:0] req_data_i = '0;
    logic [NREQ-1:0]       req_ready_o;
    logic                  fifo_write_o;
    logic [WIDTH-1:0]      fifo_wdata_o;
    logic                  fifo_read_o;
    logic                  fifo_clear_o;
    logic [WIDTH-1:0]      fifo_rdata_i = '0;
    logic                  fifo_full_i;
    logic                  fifo_empty_i;
    logic                  out_valid_o;
    logic [WIDTH-1:0]      out_data_o;
    logic                  out_ready_i = 1'b0;
    logic [IDW-1:0]        grant_id_o;
    logic                  busy_o;

    logic force_full = 1'b0;
    logic lvl_full   = 1'b0;
    logic lvl_empty  = 1'b1;
    assign fifo_full_i  = force_full | lvl_full;
    assign fifo_empty_i = lvl_empty;

    int n_cmp = 0;
    int n_err = 0;

    dma_fifo_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .OUTPUT_DELAY(OD), .SKID_DEPTH(SKID)) dut (
        .clk(clk), .rstn(rstn), .clear_i(clear_i),
        .req_valid_i(req_valid_i), .req_data_i(req_data_i), .req_ready_o(req_ready_o),
        .fifo_write_o(fifo_write_o), .fifo_wdata_o(fifo_wdata_o), .fifo_read_o(fifo_read_o),
        .fifo_clear_o(fifo_clear_o), .fifo_rdata_i(fifo_rdata_i), .fifo_full_i(fifo_full_i),
        .fifo_empty_i(fifo_empty_i), .out_valid_o(out_valid_o), .out_data_o(out_data_o),
        .out_ready_i(out_ready_i), .grant_id_o(grant_id_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
        end
    endtask

    // ---------------- environment FIFO (follows what the DUT actually drives)
    logic [WIDTH-1:0] fq[$];
    logic             rec_wr = 1'b0, rec_rd = 1'b0, rec_clr = 1'b0;
    logic [WIDTH-1:0] rec_wdata = '0;

    always begin
        @(posedge clk);
        #1;
        fifo_rdata_i = {$urandom(), $urandom(), $urandom(), $urandom()};
        if (!rstn || rec_clr) begin
            fq.delete();
        end else begin
            if (rec_rd && fq.size() > 0) begin
                fifo_rdata_i = fq.pop_front();
            end
            if (rec_wr && fq.size() < FDEPTH) begin
                fq.push_back(rec_wdata);
            end
        end
        lvl_full  = (fq.size() >= FDEPTH);
        lvl_empty = (fq.size() == 0);
    end

    // ---------------- reference model
    typedef struct {
        logic [WIDTH-1:0] d;
        int               age;
    } infl_t;

    infl_t            iq[$];
    logic [WIDTH-1:0] sq[$];
    int               m_rr = NREQ - 1;
    int               m_flush = 0;
    int               g, j, used;
    logic             e_pop, e_rd, e_run;
    logic [NREQ-1:0]  e_ready;
    logic [WIDTH-1:0] e_wdata;
    logic             prev_ok = 1'b0, prev_v = 1'b0, prev_r = 1'b0;
    logic [WIDTH-1:0] prev_d = '0;
    infl_t            nt;

    always @(negedge clk) begin
        if (!rstn) begin
            iq.delete();
            sq.delete();
            m_rr    = NREQ - 1;
            m_flush = 0;
        end
        e_run = (m_flush == 0);
        g = -1;
        if (e_run && !clear_i && !fifo_full_i) begin
            for (int k = 1; k <= NREQ; k++) begin
                j = (m_rr + k) % NREQ;
                if (g < 0 && req_valid_i[j]) g = j;
            end
        end
        e_ready = (g >= 0) ? (NREQ'(1) << g) : '0;
        e_wdata = (g >= 0) ? req_data_i[g*WIDTH +: WIDTH] : '0;
        e_pop   = (sq.size() > 0) && out_ready_i;
        used    = sq.size() + iq.size() - (e_pop ? 1 : 0);
        e_rd    = e_run && !clear_i && !fifo_empty_i && (used < SKID);

        chk("req_ready", WIDTH'(req_ready_o), WIDTH'(e_ready));
        chk("fifo_write", WIDTH'(fifo_write_o), WIDTH'(g >= 0));
        if (g >= 0) begin
            chk("fifo_wdata", fifo_wdata_o, e_wdata);
            chk("grant_id", WIDTH'(grant_id_o), WIDTH'(g));
        end
        chk("fifo_read", WIDTH'(fifo_read_o), WIDTH'(e_rd));
        chk("fifo_clear", WIDTH'(fifo_clear_o), WIDTH'(clear_i));
        chk("out_valid", WIDTH'(out_valid_o), WIDTH'(sq.size() > 0));
        if (sq.size() > 0) chk("out_data", out_data_o, sq[0]);
        chk("busy", WIDTH'(busy_o),
            WIDTH'(!fifo_empty_i || iq.size() > 0 || sq.size() > 0 || !e_run));
        if (rstn && prev_ok && prev_v && !prev_r) begin
            chk("stream_hold_valid", WIDTH'(out_valid_o), WIDTH'(1));
            chk("stream_hold_data", out_data_o, prev_d);
        end
        prev_ok = rstn && !clear_i;
        prev_v  = out_valid_o;
        prev_r  = out_ready_i;
        prev_d  = out_data_o;

        rec_wr    = fifo_write_o;
        rec_wdata = fifo_wdata_o;
        rec_rd    = fifo_read_o;
        rec_clr   = fifo_clear_o;

        if (rstn) begin
            if (clear_i) begin
                iq.delete();
                sq.delete();
                m_flush = OD;
            end else begin
                if (m_flush > 0) m_flush--;
                if (e_pop) sq.delete(0);
                while (iq.size() > 0 && iq[0].age >= OD - 1) begin
                    sq.push_back(iq[0].d);
                    iq.delete(0);
                end
                foreach (iq[i]) iq[i].age = iq[i].age + 1;
                if (e_rd && fq.size() > 0) begin
                    nt.d   = fq[0];
                    nt.age = 0;
                    iq.push_back(nt);
                end
                if (g >= 0) m_rr = g;
            end
        end
    end

    // ---------------- stimulus helpers
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic rand_data();
        for (int i = 0; i < NREQ; i++) begin
            req_data_i[i*WIDTH +: WIDTH] = {$urandom(), $urandom(), $urandom(), $urandom()};
        end
    endtask

    task automatic wait_idle(input int lim);
        req_valid_i = '0;
        clear_i     = 1'b0;
        force_full  = 1'b0;
        out_ready_i = 1'b1;
        for (int n = 0; n <= lim; n++) begin
            @(negedge clk);
            if (!busy_o) break;
            if (n == lim) begin
                n_cmp++;
                n_err++;
                $display("FAIL drain_timeout: busy_o still 1 after %0d cycles, expected 0", lim);
            end
        end
        step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    int gseq[5];
    int cnt, t_rd, t_ov;

    initial begin
        // reset values
        @(negedge clk);
        chk("reset_out_valid", WIDTH'(out_valid_o), WIDTH'(0));
        chk("reset_req_ready", WIDTH'(req_ready_o), WIDTH'(0));
        chk("reset_busy", WIDTH'(busy_o), WIDTH'(0));
        step();
        step();
        rstn = 1'b1;
        out_ready_i = 1'b1;

        // all requesters valid: 0,1,2,3,0
        req_valid_i = '1;
        rand_data();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            gseq[i] = fifo_write_o ? int'(grant_id_o) : -1;
            step();
            rand_data();
        end
        chk("rr_seq0", WIDTH'(gseq[0]), WIDTH'(0));
        chk("rr_seq1", WIDTH'(gseq[1]), WIDTH'(1));
        chk("rr_seq2", WIDTH'(gseq[2]), WIDTH'(2));
        chk("rr_seq3", WIDTH'(gseq[3]), WIDTH'(3));
        chk("rr_seq4", WIDTH'(gseq[4]), WIDTH'(0));
        wait_idle(100);

        // req 2 streaming, req 0 joins: no starvation
        req_valid_i = 4'b0100;
        for (int i = 0; i < 4; i++) begin
            rand_data();
            step();
        end
        req_valid_i = 4'b0101;
        rand_data();
        @(negedge clk);
        chk("join_grant0", WIDTH'(grant_id_o), WIDTH'(0));
        step();
        rand_data();
        @(negedge clk);
        chk("join_grant1", WIDTH'(grant_id_o), WIDTH'(2));
        wait_idle(100);

        // backpressure: exactly SKID reads, then 13 consecutive beats
        out_ready_i = 1'b0;
        req_valid_i = '1;
        cnt = 0;
        for (int i = 0; i < 22; i++) begin
            if (i == 13) req_valid_i = '0;
            rand_data();
            @(negedge clk);
            if (fifo_read_o) cnt++;
            step();
        end
        chk("stall_read_count", WIDTH'(cnt), WIDTH'(SKID));
        out_ready_i = 1'b1;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!out_valid_o) break;
            cnt++;
            step();
        end
        chk("consecutive_beats", WIDTH'(cnt), WIDTH'(13));
        wait_idle(100);

        // read-to-valid latency
        req_valid_i = 4'b0001;
        rand_data();
        step();
        req_valid_i = '0;
        t_rd = -1;
        t_ov = -1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (fifo_read_o && t_rd < 0) t_rd = c;
            if (out_valid_o && t_ov < 0) t_ov = c;
            step();
        end
        chk("read_to_valid_latency", WIDTH'(t_ov - t_rd), WIDTH'(OD + 1));
        wait_idle(100);

        // full blocks grants
        force_full  = 1'b1;
        req_valid_i = '1;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            rand_data();
            @(negedge clk);
            if (req_ready_o != '0 || fifo_write_o) cnt++;
            step();
        end
        chk("full_grant_count", WIDTH'(cnt), WIDTH'(0));
        force_full = 1'b0;
        rand_data();
        @(negedge clk);
        chk("grant_after_full", WIDTH'(fifo_write_o), WIDTH'(1));
        wait_idle(100);

        // clear with data in skid and FIFO
        out_ready_i = 1'b0;
        req_valid_i = '1;
        for (int i = 0; i < 10; i++) begin
            if (i == 6) req_valid_i = '0;
            rand_data();
            step();
        end
        out_ready_i = 1'b1;
        clear_i     = 1'b1;
        @(negedge clk);
        chk("clear_pulse", WIDTH'(fifo_clear_o), WIDTH'(1));
        chk("clear_no_read", WIDTH'(fifo_read_o), WIDTH'(0));
        step();
        clear_i     = 1'b0;
        req_valid_i = '1;
        @(negedge clk);
        chk("clear_valid_drop", WIDTH'(out_valid_o), WIDTH'(0));
        chk("clear_pulse_end", WIDTH'(fifo_clear_o), WIDTH'(0));
        chk("flush_no_grant", WIDTH'(fifo_write_o), WIDTH'(0));
        step();
        req_valid_i = '0;
        @(negedge clk);
        chk("busy_after_flush", WIDTH'(busy_o), WIDTH'(0));
        step();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            req_valid_i = NREQ'($urandom());
            out_ready_i = ($urandom_range(0, 3) != 0);
            force_full  = ($urandom_range(0, 15) == 0);
            clear_i     = ($urandom_range(0, 63) == 0);
            rand_data();
            step();
        end
        wait_idle(200);

        // asynchronous reset mid-operation
        out_ready_i = 1'b0;
        req_valid_i = '1;
        for (int i = 0; i < 6; i++) begin
            rand_data();
            step();
        end
        @(posedge clk);
        #3;
        rstn        = 1'b0;
        req_valid_i = '0;
        #1;
        chk("async_reset_valid", WIDTH'(out_valid_o), WIDTH'(0));
        step();
        step();
        rstn = 1'b1;
        wait_idle(50);
        req_valid_i = '1;
        rand_data();
        @(negedge clk);
        chk("rr_after_reset", WIDTH'(grant_id_o), WIDTH'(0));
        wait_idle(100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
